// File: rtl/arf_rat_pkg.sv
// rtl/arf_rat_pkg.sv - shared types and sizes for the ARF/RAT slice
package global_defs;

  localparam int ARF_N_ENTRIES  = 32;
  localparam int ROB_N_ENTRIES  = 16;
  localparam int REG_DATA_WIDTH = 32;
  localparam int ARF_ID_WIDTH   = $clog2(ARF_N_ENTRIES);
  localparam int ROB_ID_WIDTH   = $clog2(ROB_N_ENTRIES);

  typedef logic [ARF_ID_WIDTH-1:0]   arf_id_t;
  typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    logic    valid;
    rob_id_t rob_id;
  } rat_entry_t;

  typedef struct packed {
    logic      renamed;
    rob_id_t   rob_id;
    reg_data_t data;
  } lookup_t;

endpackage

// File: rtl/arf_rat_entry.sv
// rtl/arf_rat_entry.sv - one architectural register: committed data plus its alias entry
module arf_rat_entry
  import global_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rename,
  input  rob_id_t    i_rename_rob_id,
  input  logic       i_retire,
  input  rob_id_t    i_retire_rob_id,
  input  reg_data_t  i_retire_data,
  input  logic       i_flush,
  output reg_data_t  o_data,
  output rat_entry_t o_rat
);

  reg_data_t  r_data;
  rat_entry_t r_rat;

  // Committed value: every retire to this register lands, regardless of ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_retire) begin
      r_data <= i_retire_data;
    end
  end

  // Alias entry: flush beats rename, rename beats the owner-matched release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rat <= '0;
    end else if (i_flush) begin
      r_rat.valid <= 1'b0;
    end else if (i_rename) begin
      r_rat.valid  <= 1'b1;
      r_rat.rob_id <= i_rename_rob_id;
    end else if (i_retire && r_rat.valid && (r_rat.rob_id == i_retire_rob_id)) begin
      r_rat.valid <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_rat  = r_rat;

endmodule

// File: rtl/arf_rat.sv
// rtl/arf_rat.sv - architectural register file + alias table; optional ARF_RAT_BYPASS_EN retire bypass
module arf_rat
  import global_defs::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      dispatch_fire,
  input  logic      dispatch_dst_valid,
  input  arf_id_t   dispatch_dst_arf_id,
  input  rob_id_t   dispatch_rob_id,
  input  arf_id_t   src1_arf_id,
  output logic      src1_renamed,
  output rob_id_t   src1_rob_id,
  output reg_data_t src1_reg_data,
  input  arf_id_t   src2_arf_id,
  output logic      src2_renamed,
  output rob_id_t   src2_rob_id,
  output reg_data_t src2_reg_data,
  input  logic      retire,
  input  rob_id_t   retire_rob_id,
  input  arf_id_t   retire_arf_id,
  input  reg_data_t retire_reg_data,
  input  logic      retire_redirect_pc_valid
);

  reg_data_t  w_arf [ARF_N_ENTRIES];
  rat_entry_t w_rat [ARF_N_ENTRIES];
  arf_id_t    w_src_id [2];
  lookup_t    w_lk [2];
  logic       w_rename_any;

  assign w_rename_any = dispatch_fire & dispatch_dst_valid;

  // x0 has no storage; it reads as an unmapped zero.
  assign w_arf[0] = '0;
  assign w_rat[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < ARF_N_ENTRIES; gi++) begin : g_reg
      arf_rat_entry u_entry (
        .clk             (clk),
        .rst             (rst),
        .i_rename        (w_rename_any && (dispatch_dst_arf_id == arf_id_t'(gi))),
        .i_rename_rob_id (dispatch_rob_id),
        .i_retire        (retire && (retire_arf_id == arf_id_t'(gi))),
        .i_retire_rob_id (retire_rob_id),
        .i_retire_data   (retire_reg_data),
        .i_flush         (retire_redirect_pc_valid),
        .o_data          (w_arf[gi]),
        .o_rat           (w_rat[gi])
      );
    end
  endgenerate

  assign w_src_id[0] = src1_arf_id;
  assign w_src_id[1] = src2_arf_id;

  // Both read ports: pre-edge RAT/ARF state, optionally bypassing a matching retire.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_lk[k].renamed = w_rat[w_src_id[k]].valid;
      w_lk[k].rob_id  = w_rat[w_src_id[k]].rob_id;
      w_lk[k].data    = w_arf[w_src_id[k]];
`ifdef ARF_RAT_BYPASS_EN
      if (retire && (retire_arf_id == w_src_id[k]) && w_rat[w_src_id[k]].valid &&
          (w_rat[w_src_id[k]].rob_id == retire_rob_id)) begin
        w_lk[k].renamed = 1'b0;
        w_lk[k].data    = retire_reg_data;
      end
`endif
      if (w_src_id[k] == '0) begin
        w_lk[k] = '0;
      end
    end
  end

  assign src1_renamed  = w_lk[0].renamed;
  assign src1_rob_id   = w_lk[0].rob_id;
  assign src1_reg_data = w_lk[0].data;
  assign src2_renamed  = w_lk[1].renamed;
  assign src2_rob_id   = w_lk[1].rob_id;
  assign src2_reg_data = w_lk[1].data;

endmodule

// File: tb/tb_arf_rat.sv
// tb/tb_arf_rat.sv - directed scoreboard bench for arf_rat (either ARF_RAT_BYPASS_EN build)
module tb_arf_rat;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_fire, dispatch_dst_valid;
  logic [4:0]  dispatch_dst_arf_id;
  logic [3:0]  dispatch_rob_id;
  logic [4:0]  src1_arf_id, src2_arf_id;
  logic        src1_renamed, src2_renamed;
  logic [3:0]  src1_rob_id, src2_rob_id;
  logic [31:0] src1_reg_data, src2_reg_data;
  logic        retire;
  logic [3:0]  retire_rob_id;
  logic [4:0]  retire_arf_id;
  logic [31:0] retire_reg_data;
  logic        retire_redirect_pc_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          port;
    logic        ren;
    logic [3:0]  rob;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  arf_rat dut (
    .clk                      (clk),
    .rst                      (rst),
    .dispatch_fire            (dispatch_fire),
    .dispatch_dst_valid       (dispatch_dst_valid),
    .dispatch_dst_arf_id      (dispatch_dst_arf_id),
    .dispatch_rob_id          (dispatch_rob_id),
    .src1_arf_id              (src1_arf_id),
    .src1_renamed             (src1_renamed),
    .src1_rob_id              (src1_rob_id),
    .src1_reg_data            (src1_reg_data),
    .src2_arf_id              (src2_arf_id),
    .src2_renamed             (src2_renamed),
    .src2_rob_id              (src2_rob_id),
    .src2_reg_data            (src2_reg_data),
    .retire                   (retire),
    .retire_rob_id            (retire_rob_id),
    .retire_arf_id            (retire_arf_id),
    .retire_reg_data          (retire_reg_data),
    .retire_redirect_pc_valid (retire_redirect_pc_valid)
  );

  task automatic clear_inputs();
    dispatch_fire = 0; dispatch_dst_valid = 0; dispatch_dst_arf_id = 0; dispatch_rob_id = 0;
    retire = 0; retire_rob_id = 0; retire_arf_id = 0; retire_reg_data = 0;
    retire_redirect_pc_valid = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_dispatch(input logic [4:0] arf, input logic [3:0] rob);
    dispatch_fire = 1; dispatch_dst_valid = 1; dispatch_dst_arf_id = arf; dispatch_rob_id = rob;
  endtask

  task automatic set_retire(input logic [3:0] rob, input logic [4:0] arf, input logic [31:0] d);
    retire = 1; retire_rob_id = rob; retire_arf_id = arf; retire_reg_data = d;
  endtask

  task automatic look(input string tag, input int port, input logic [4:0] arf,
                      input logic ren, input logic [3:0] rob, input logic [31:0] d);
    exp_t e;
    exp_t got;
    logic        o_ren;
    logic [3:0]  o_rob;
    logic [31:0] o_data;
    e.tag = tag; e.port = port; e.ren = ren; e.rob = rob; e.data = d;
    if (port == 1) src1_arf_id = arf; else src2_arf_id = arf;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    o_ren  = (got.port == 1) ? src1_renamed  : src2_renamed;
    o_rob  = (got.port == 1) ? src1_rob_id   : src2_rob_id;
    o_data = (got.port == 1) ? src1_reg_data : src2_reg_data;
    checks++;
    assert (o_ren === got.ren) else begin
      errors++;
      $error("FAIL %s renamed: got %0b expected %0b", got.tag, o_ren, got.ren);
    end
    checks++;
    if (got.ren) begin
      assert (o_rob === got.rob) else begin
        errors++;
        $error("FAIL %s rob_id: got %0d expected %0d", got.tag, o_rob, got.rob);
      end
    end else begin
      assert (o_data === got.data) else begin
        errors++;
        $error("FAIL %s data: got %h expected %h", got.tag, o_data, got.data);
      end
    end
  endtask

  initial begin
    clear_inputs();
    src1_arf_id = 0; src2_arf_id = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    look("reset_x5", 1, 5, 0, 0, 32'h0);
    look("reset_x0", 2, 0, 0, 0, 32'h0);

    // basic rename then retire
    set_dispatch(5, 3); tick();
    look("rename_x5", 1, 5, 1, 3, 0);
    set_retire(3, 5, 32'hDEAD);
`ifdef ARF_RAT_BYPASS_EN
    look("bypass_x5", 1, 5, 0, 0, 32'hDEAD);
`else
    look("nobypass_x5", 1, 5, 1, 3, 0);
`endif
    tick();
    look("retired_x5", 1, 5, 0, 0, 32'hDEAD);

    // younger owner keeps the mapping
    set_dispatch(5, 3); tick();
    set_dispatch(5, 7); tick();
    set_retire(3, 5, 32'h11);
`ifdef ARF_RAT_BYPASS_EN
    look("young_nobyp", 2, 5, 1, 7, 0);
`endif
    tick();
    look("young_owner", 2, 5, 1, 7, 0);
    set_retire(7, 5, 32'h22); tick();
    look("young_retired", 2, 5, 0, 0, 32'h22);

    // rename and retire of the same reg in one cycle
    set_dispatch(6, 4); tick();
    set_dispatch(6, 9); set_retire(4, 6, 32'h55); tick();
    look("simul_rat", 1, 6, 1, 9, 0);
    retire_redirect_pc_valid = 1; tick();
    look("simul_arf", 1, 6, 0, 0, 32'h55);

    // flush drops all mappings and a same-cycle rename
    set_dispatch(1, 1); tick();
    set_dispatch(2, 5); tick();
    set_dispatch(3, 6); tick();
    look("pre_flush_x1", 1, 1, 1, 1, 0);
    look("pre_flush_x3", 2, 3, 1, 6, 0);
    retire_redirect_pc_valid = 1; set_dispatch(4, 2); tick();
    look("flush_x1", 1, 1, 0, 0, 0);
    look("flush_x2", 2, 2, 0, 0, 0);
    look("flush_x3", 1, 3, 0, 0, 0);
    look("flush_x4", 2, 4, 0, 0, 0);

    // x0 ignores dispatch and retire
    set_dispatch(0, 8); set_retire(8, 0, 32'hFFFF_FFFF); tick();
    look("x0_src1", 1, 0, 0, 0, 0);
    look("x0_src2", 2, 0, 0, 0, 0);

    // retire to an unmapped reg writes the ARF
    set_retire(2, 8, 32'h88); tick();
    look("unmapped_ret", 1, 8, 0, 0, 32'h88);

    // mid-operation reset overrides everything
    rst = 1; set_dispatch(7, 5); set_retire(5, 7, 32'h77); tick();
    rst = 0;
    look("rst_x7", 1, 7, 0, 0, 0);
    look("rst_x5", 2, 5, 0, 0, 0);
    look("rst_x8", 1, 8, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
